board_input_conditioner: RTL



---
 rtl/board_io_pkg.sv | 25 ++
 rtl/debounce_channel.sv | 74 +++++++
 rtl/board_input_conditioner.sv | 62 ++++++
 3 files changed

// File: rtl/board_io_pkg.sv
// Shared board I/O definitions: prescaler sizing, a width helper and the
// channel map of the button / DIP switch input vector.
package board_io_pkg;

  localparam int CH_DIP1 = 0;
  localparam int CH_DIP2 = 1;
  localparam int CH_DIP3 = 2;
  localparam int CH_DIP4 = 3;
  localparam int CH_BTN  = 4;

  function automatic int tick_cycles(input int clkspeed);
    return clkspeed / 1000;
  endfunction

  // Never returns less than 1 so that a count of one state still gets a real vector.
  function automatic int clog2_min1(input int value);
    int w;
    w = 0;
    for (int b = 0; b < 31; b++) begin
      if ((1 << b) < value) w = b + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One input channel: two-flop synchroniser, tick-based stability counter,
// debounced level register and registered rise/fall pulses.
module debounce_channel
  import board_io_pkg::*;
#(
  parameter int   DEBOUNCE_MS = 10,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  input  logic tick_i,
  output logic clean_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int            CW   = clog2_min1(DEBOUNCE_MS);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_MS - 1);

  logic          s1_q;
  logic          s2_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          clean_q;
  logic          clean_d;
  logic          rise_q;
  logic          rise_d;
  logic          fall_q;
  logic          fall_d;

  // Any sample agreeing with the current level restarts qualification.
  always_comb begin
    cnt_d   = cnt_q;
    clean_d = clean_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (s2_q == clean_q) begin
      cnt_d = '0;
    end else if (tick_i) begin
      if (cnt_q == LAST) begin
        clean_d = s2_q;
        cnt_d   = '0;
        rise_d  = s2_q;
        fall_d  = ~s2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q    <= RESET_VAL;
      s2_q    <= RESET_VAL;
      cnt_q   <= '0;
      clean_q <= RESET_VAL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      s1_q    <= raw_i;
      s2_q    <= s1_q;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign clean_o = clean_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/board_input_conditioner.sv
// Board input conditioner: one shared 1 ms prescaler driving WIDTH
// independent debounce channels for the push-button and DIP switches.
module board_input_conditioner
  import board_io_pkg::*;
#(
  parameter int               CLKSPEED    = 40000000,
  parameter int               DEBOUNCE_MS = 10,
  parameter int               WIDTH       = 5,
  parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] clean,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             tick
);

  localparam int            TICK_CYCLES = tick_cycles(CLKSPEED);
  localparam int            PW          = clog2_min1(TICK_CYCLES);
  localparam logic [PW-1:0] PRE_LAST    = PW'(TICK_CYCLES - 1);

  logic [PW-1:0] pre_q;
  logic [PW-1:0] pre_d;
  logic          tick_q;
  logic          tick_d;

  always_comb begin
    tick_d = (pre_q == PRE_LAST);
    pre_d  = tick_d ? '0 : pre_q + PW'(1);
  end

  // The strobe is registered so it lands one cycle after the terminal count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_MS(DEBOUNCE_MS),
      .RESET_VAL  (RESET_VAL[i])
    ) u_ch (
      .clk    (clk),
      .reset  (reset),
      .raw_i  (raw_in[i]),
      .tick_i (tick_q),
      .clean_o(clean[i]),
      .rise_o (rise[i]),
      .fall_o (fall[i])
    );
  end

endmodule
